// File: rtl/tmds_pkg.sv
// Shared TMDS constants, phase type and DDR pair selection
// for the serial-domain symbol sequencer.
package tmds_pkg;

   localparam int SYM_W = 10;
   localparam int PAIRS = 5;

   typedef logic [2:0] phase_t;

   localparam phase_t LAST_PHASE = 3'(PAIRS - 1);

   localparam logic [SYM_W-1:0] CTRL_00 = 10'h354;
   localparam logic [SYM_W-1:0] CTRL_01 = 10'h0AB;
   localparam logic [SYM_W-1:0] CTRL_10 = 10'h154;
   localparam logic [SYM_W-1:0] CTRL_11 = 10'h2AB;

   // Low for bits 0-4 and high for bits 5-9, so the clock
   // lane is low for the first half of every symbol slot.
   localparam logic [SYM_W-1:0] CLK_PATTERN_DEFAULT = 10'b11111_00000;

   // Pair p carries bit 2p on the rising edge, 2p+1 on the falling.
   function automatic logic [1:0] pair_at(
      input logic [SYM_W-1:0] s,
      input phase_t           p
   );
      logic [1:0] r;
      r = 2'b00;
      unique case (p)
         3'd0:    r = {s[0], s[1]};
         3'd1:    r = {s[2], s[3]};
         3'd2:    r = {s[4], s[5]};
         3'd3:    r = {s[6], s[7]};
         3'd4:    r = {s[8], s[9]};
         default: r = 2'b00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/tmds_lane_shifter.sv
// One TMDS lane: holds the current 10-bit symbol and emits
// the registered DDR pair selected by the frame phase.
module tmds_lane_shifter
   import tmds_pkg::*;
#(
   parameter logic [SYM_W-1:0] RST_VAL = CTRL_00
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [SYM_W-1:0] load_val_i,
   input  logic             load_i,
   input  phase_t           phase_i,
   output logic [1:0]       pair_o
);

   logic [SYM_W-1:0] sym_q, sym_d;
   logic [1:0]       pair_q, pair_d;

   // Next symbol on the load strobe; pair taken from the current symbol.
   always_comb begin
      sym_d  = load_i ? load_val_i : sym_q;
      pair_d = pair_at(sym_q, phase_i);
   end

   // Symbol and output pair registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         sym_q  <= RST_VAL;
         pair_q <= 2'b00;
      end else begin
         sym_q  <= sym_d;
         pair_q <= pair_d;
      end
   end

   assign pair_o = pair_q;

endmodule

// File: rtl/tmds_ddr_sequencer.sv
// Feeds the four TMDS DDR cells from a stream of symbol
// triplets, one triplet buffered ahead, idling on underflow.
module tmds_ddr_sequencer
   import tmds_pkg::*;
#(
   parameter logic [SYM_W-1:0] IDLE_SYM    = CTRL_00,
   parameter logic [SYM_W-1:0] CLK_PATTERN = CLK_PATTERN_DEFAULT,
   parameter int               UNDERFLOW_W = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   sym_valid,
   output logic                   sym_ready,
   input  logic [3*SYM_W-1:0]     sym_data,
   output logic [1:0]             ddr_d0,
   output logic [1:0]             ddr_d1,
   output logic [1:0]             ddr_d2,
   output logic [1:0]             ddr_clk,
   output logic [2:0]             frame_phase,
   output logic [UNDERFLOW_W-1:0] underflow_count,
   input  logic                   underflow_clear
);

   phase_t                 phase_q, phase_d;
   logic                   hold_full_q, hold_full_d;
   logic [3*SYM_W-1:0]     hold_q, hold_d;
   logic [UNDERFLOW_W-1:0] ufl_q, ufl_d;

   logic               last;
   logic               accept;
   logic               take_hold;
   logic               starve;
   logic [3*SYM_W-1:0] load_sym;

   assign last      = (phase_q == LAST_PHASE);
   assign sym_ready = enable & ~reset & (~hold_full_q | last);
   assign accept    = sym_valid & sym_ready;
   assign take_hold = last & hold_full_q & enable;
   assign starve    = last & enable & ~hold_full_q;
   assign load_sym  = take_hold ? hold_q : {3{IDLE_SYM}};

   // Phase wrap, holding register refill/drain, underflow count.
   always_comb begin
      phase_d     = last ? '0 : phase_q + 3'd1;
      hold_d      = accept ? sym_data : hold_q;
      hold_full_d = accept | (hold_full_q & ~last);
      ufl_d       = ufl_q;
      if (starve && (ufl_q != '1)) begin
         ufl_d = ufl_q + 1'b1;
      end
      if (underflow_clear) begin
         ufl_d = '0;
      end
   end

   // Control state registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         phase_q     <= '0;
         hold_full_q <= 1'b0;
         hold_q      <= '0;
         ufl_q       <= '0;
      end else begin
         phase_q     <= phase_d;
         hold_full_q <= hold_full_d;
         hold_q      <= hold_d;
         ufl_q       <= ufl_d;
      end
   end

   assign frame_phase     = phase_q;
   assign underflow_count = ufl_q;

   tmds_lane_shifter #(.RST_VAL(IDLE_SYM)) u_lane0 (
      .clock      (clock),
      .reset      (reset),
      .load_val_i (load_sym[SYM_W-1:0]),
      .load_i     (last),
      .phase_i    (phase_q),
      .pair_o     (ddr_d0)
   );

   tmds_lane_shifter #(.RST_VAL(IDLE_SYM)) u_lane1 (
      .clock      (clock),
      .reset      (reset),
      .load_val_i (load_sym[2*SYM_W-1:SYM_W]),
      .load_i     (last),
      .phase_i    (phase_q),
      .pair_o     (ddr_d1)
   );

   tmds_lane_shifter #(.RST_VAL(IDLE_SYM)) u_lane2 (
      .clock      (clock),
      .reset      (reset),
      .load_val_i (load_sym[3*SYM_W-1:2*SYM_W]),
      .load_i     (last),
      .phase_i    (phase_q),
      .pair_o     (ddr_d2)
   );

   // The clock lane reloads its fixed pattern every slot.
   tmds_lane_shifter #(.RST_VAL(CLK_PATTERN)) u_lane_clk (
      .clock      (clock),
      .reset      (reset),
      .load_val_i (CLK_PATTERN),
      .load_i     (last),
      .phase_i    (phase_q),
      .pair_o     (ddr_clk)
   );

endmodule
